// File: rtl/rule_dram_pkg.sv
// Shared definitions for the rule memory controller.
//   - default address/data widths of the 32768 x 4-bit rule memory
//   - controller state enum (idle operation / bulk clear sweep)
//   - idx_w(): width of a requester index, never less than one bit
package rule_dram_pkg;

    localparam int unsigned DEF_NUM_REQ = 4;
    localparam int unsigned DEF_ADDR_W  = 15;
    localparam int unsigned DEF_DATA_W  = 4;

    typedef enum logic [0:0] {
        StIdle,
        StClear
    } state_e;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rule_dram_ctrl_if.sv
// Bus bundle between the rule memory controller and its environment.
//   lookup side : req_valid/req_addr/req_ready, rsp_valid/rsp_id/rsp_data
//   config side : cfg_valid/cfg_ready/cfg_addr/cfg_data, clr_start/clr_busy
//   memory side : port A (ram_ena/wea/addra/dina), port B (ram_enb/addrb/doutb)
// slave  = controller view, master = view of requesters, config path and memory.
interface rule_dram_ctrl_if #(
    parameter int unsigned NUM_REQ = rule_dram_pkg::DEF_NUM_REQ,
    parameter int unsigned ADDR_W  = rule_dram_pkg::DEF_ADDR_W,
    parameter int unsigned DATA_W  = rule_dram_pkg::DEF_DATA_W
);
    import rule_dram_pkg::*;

    localparam int unsigned IDX_W = idx_w(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      rsp_valid;
    logic [IDX_W-1:0]          rsp_id;
    logic [DATA_W-1:0]         rsp_data;

    logic                      cfg_valid;
    logic                      cfg_ready;
    logic [ADDR_W-1:0]         cfg_addr;
    logic [DATA_W-1:0]         cfg_data;
    logic                      clr_start;
    logic                      clr_busy;

    logic                      ram_ena;
    logic                      ram_wea;
    logic [ADDR_W-1:0]         ram_addra;
    logic [DATA_W-1:0]         ram_dina;
    logic                      ram_enb;
    logic [ADDR_W-1:0]         ram_addrb;
    logic [DATA_W-1:0]         ram_doutb;

    modport slave (
        input  req_valid, req_addr, cfg_valid, cfg_addr, cfg_data, clr_start, ram_doutb,
        output req_ready, rsp_valid, rsp_id, rsp_data, cfg_ready, clr_busy,
               ram_ena, ram_wea, ram_addra, ram_dina, ram_enb, ram_addrb
    );

    modport master (
        output req_valid, req_addr, cfg_valid, cfg_addr, cfg_data, clr_start, ram_doutb,
        input  req_ready, rsp_valid, rsp_id, rsp_data, cfg_ready, clr_busy,
               ram_ena, ram_wea, ram_addra, ram_dina, ram_enb, ram_addrb
    );

endinterface

// File: rtl/rule_rr_arb.sv
// Round-robin arbiter over an already-masked eligible vector.
//   clk, rst_n : clock, asynchronous active-low reset
//   eligible   : requesters allowed to win this cycle
//   gnt        : one-hot grant
//   gnt_idx    : index of the granted requester (0 when no grant)
//   gnt_valid  : a grant was issued
// The search starts one past the last winner (rr_ptr) and wraps; rr_ptr only
// moves when a grant occurs. After reset rr_ptr = NUM_REQ-1, so requester 0
// has first priority.
module rule_rr_arb import rule_dram_pkg::*; #(
    parameter  int unsigned NUM_REQ = DEF_NUM_REQ,
    localparam int unsigned IDX_W   = idx_w(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] eligible,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid
);

    logic [IDX_W-1:0] rr_ptr_q;

    int  hi_idx;
    int  lo_idx;
    int  sel;
    logic hi_found;
    logic lo_found;

    // Lowest eligible index above the pointer wins; otherwise wrap to the
    // lowest eligible index at or below it. Descending scan keeps the lowest.
    always_comb begin
        hi_idx   = 0;
        lo_idx   = 0;
        hi_found = 1'b0;
        lo_found = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                if (i > int'(rr_ptr_q)) begin
                    hi_found = 1'b1;
                    hi_idx   = i;
                end else begin
                    lo_found = 1'b1;
                    lo_idx   = i;
                end
            end
        end
        sel       = hi_found ? hi_idx : lo_idx;
        gnt_valid = hi_found | lo_found;
        gnt_idx   = gnt_valid ? IDX_W'(sel) : '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            gnt[i] = gnt_valid && (i == sel);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= IDX_W'(NUM_REQ - 1);
        end else if (gnt_valid) begin
            rr_ptr_q <= gnt_idx;
        end
    end

endmodule

// File: rtl/rule_dram_ctrl.sv
// Arbiter and sequencer for the rule memory (write port A, read port B,
// one-cycle read latency).
//   clk, rst_n : single clock, asynchronous active-low reset
//   bus        : rule_dram_ctrl_if.slave
//     lookups  : NUM_REQ requesters share port B round-robin; responses come
//                back one cycle after the grant, tagged with the requester id
//     config   : single-word writes on port A (cfg_*), bulk clear (clr_start)
//     memory   : port A / port B controls, ram_doutb passed to rsp_data
// A lookup whose address equals a cfg write accepted in the same cycle is held
// off for that cycle so the two ports never touch the same word together.
module rule_dram_ctrl import rule_dram_pkg::*; #(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W
) (
    input logic             clk,
    input logic             rst_n,
    rule_dram_ctrl_if.slave bus
);

    localparam int unsigned       IDX_W     = idx_w(NUM_REQ);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  cnt_q, cnt_d;

    logic               cfg_wr;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_valid;

    logic               rsp_valid_q;
    logic [IDX_W-1:0]   rsp_id_q;

    // Collision mask; nothing is eligible during the sweep.
    always_comb begin
        cfg_wr   = (state_q == StIdle) && bus.cfg_valid;
        eligible = '0;
        if (state_q == StIdle) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                eligible[i] = bus.req_valid[i] &&
                              !(cfg_wr && (bus.req_addr[i*ADDR_W +: ADDR_W] == bus.cfg_addr));
            end
        end
    end

    rule_rr_arb #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .eligible  (eligible),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    // A cfg write in the clr_start cycle still lands; the sweep overwrites it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (bus.clr_start) begin
                    state_d = StClear;
                    cnt_d   = '0;
                end
            end
            StClear: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Port muxing. Unused address/data buses are parked at zero.
    always_comb begin
        bus.cfg_ready = (state_q == StIdle);
        bus.clr_busy  = (state_q == StClear);
        bus.ram_ena   = 1'b0;
        bus.ram_wea   = 1'b0;
        bus.ram_addra = '0;
        bus.ram_dina  = '0;
        if (state_q == StClear) begin
            bus.ram_ena   = 1'b1;
            bus.ram_wea   = 1'b1;
            bus.ram_addra = cnt_q;
        end else if (cfg_wr) begin
            bus.ram_ena   = 1'b1;
            bus.ram_wea   = 1'b1;
            bus.ram_addra = bus.cfg_addr;
            bus.ram_dina  = bus.cfg_data;
        end

        bus.req_ready = gnt;
        bus.ram_enb   = gnt_valid;
        bus.ram_addrb = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                bus.ram_addrb = bus.req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // Response tag tracks the one-cycle read latency of port B.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
        end else begin
            rsp_valid_q <= gnt_valid;
            rsp_id_q    <= gnt_idx;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = bus.ram_doutb;

endmodule

// File: tb/tb_rule_dram_ctrl.sv
module tb_rule_dram_ctrl;

    localparam int unsigned NR  = 4;
    localparam int unsigned AW  = 15;
    localparam int unsigned DW  = 4;
    localparam int          MEM = 1 << AW;

    logic clk;
    logic rst_n;

    rule_dram_ctrl_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

    rule_dram_ctrl #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Memory behind the controller: write port A, registered read port B.
    logic [DW-1:0] mem [0:MEM-1];
    always @(posedge clk) begin
        if (bus.ram_ena && bus.ram_wea) mem[bus.ram_addra] <= bus.ram_dina;
        if (bus.ram_enb) bus.ram_doutb <= mem[bus.ram_addrb];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int m_last;                     // model: last granted requester
    logic [DW-1:0] gold [0:MEM-1];  // model: expected memory contents
    logic [AW-1:0] pool [8];

    // Reference: first requester after the last winner whose request is not
    // hit by an accepted same-address write. -1 when nobody can be served.
    function automatic int exp_winner(input logic [NR-1:0] v, input logic [NR*AW-1:0] a,
                                      input logic cv, input logic [AW-1:0] ca, input int last);
        for (int k = 1; k <= NR; k++) begin
            int i = (last + k) % NR;
            if (v[i] && !(cv && a[i*AW +: AW] == ca)) return i;
        end
        return -1;
    endfunction

    task automatic set_addr(input int i, input logic [AW-1:0] a);
        bus.req_addr[i*AW +: AW] = a;
    endtask

    task automatic zero_inputs();
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.cfg_valid = 1'b0;
        bus.cfg_addr  = '0;
        bus.cfg_data  = '0;
        bus.clr_start = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        zero_inputs();
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        m_last = NR - 1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        zero_inputs();
        #1;
        checks++;
        if ({bus.rsp_valid, bus.clr_busy, bus.req_ready, bus.ram_ena, bus.ram_wea, bus.ram_enb}
            !== '0) begin
            errors++;
            $display("FAIL reset_ctrl got rv=%b busy=%b rdy=%b ena=%b wea=%b enb=%b want all 0",
                     bus.rsp_valid, bus.clr_busy, bus.req_ready, bus.ram_ena, bus.ram_wea,
                     bus.ram_enb);
        end
        checks++;
        if ({bus.ram_addra, bus.ram_dina, bus.ram_addrb, bus.rsp_id} !== '0) begin
            errors++;
            $display("FAIL reset_bus got addra=%h dina=%h addrb=%h id=%0d want 0",
                     bus.ram_addra, bus.ram_dina, bus.ram_addrb, bus.rsp_id);
        end
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        m_last = NR - 1;
        #1;
        checks++;
        if (bus.cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_cfg_ready got %b want 1", bus.cfg_ready);
        end
    endtask

    task automatic preload();
        logic [AW-1:0] a [8];
        logic [DW-1:0] d [8];
        a = '{15'h0010, 15'h0020, 15'h0030, 15'h0040, 15'h0100, 15'h4000, 15'h7FFF, 15'h0050};
        d = '{4'h3, 4'h9, 4'hC, 4'h1, 4'hA, 4'h6, 4'hE, 4'hF};
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            bus.cfg_valid = 1'b1;
            bus.cfg_addr  = a[k];
            bus.cfg_data  = d[k];
            gold[a[k]]    = d[k];
            pool[k]       = a[k];
        end
        @(negedge clk);
        bus.cfg_valid = 1'b0;
    endtask

    task automatic test_single_lookup();
        @(negedge clk);
        bus.req_valid = 4'b0100;
        set_addr(2, 15'h0100);
        #1;
        checks++;
        if (bus.req_ready !== 4'b0100 || bus.ram_enb !== 1'b1 || bus.ram_addrb !== 15'h0100) begin
            errors++;
            $display("FAIL single_grant got rdy=%b enb=%b addrb=%h want 0100 1 0100",
                     bus.req_ready, bus.ram_enb, bus.ram_addrb);
        end
        m_last = 2;
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd2 || bus.rsp_data !== 4'hA) begin
            errors++;
            $display("FAIL single_rsp got v=%b id=%0d data=%h want 1 2 a",
                     bus.rsp_valid, bus.rsp_id, bus.rsp_data);
        end
        bus.req_valid = '0;
    endtask

    task automatic test_fairness();
        int            prev_id;
        logic [DW-1:0] prev_data;
        do_reset();
        prev_id   = 0;
        prev_data = '0;
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            if (c > 0) begin
                checks++;
                if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'(prev_id) ||
                    bus.rsp_data !== prev_data) begin
                    errors++;
                    $display("FAIL fair_rsp%0d got v=%b id=%0d data=%h want 1 %0d %h", c,
                             bus.rsp_valid, bus.rsp_id, bus.rsp_data, prev_id, prev_data);
                end
            end
            if (c == 8) begin
                bus.req_valid = '0;
            end else begin
                bus.req_valid = '1;
                for (int i = 0; i < NR; i++) set_addr(i, pool[$urandom_range(0, 7)]);
                #1;
                checks++;
                if (bus.req_ready !== 4'(1 << (c % NR))) begin
                    errors++;
                    $display("FAIL fair_grant%0d got %b want %b", c, bus.req_ready,
                             4'(1 << (c % NR)));
                end
                prev_id   = c % NR;
                prev_data = gold[bus.req_addr[prev_id*AW +: AW]];
            end
        end
        m_last = NR - 1;
    endtask

    task automatic test_collision();
        logic [DW-1:0] d1;
        do_reset();
        @(negedge clk);
        bus.cfg_valid = 1'b1;
        bus.cfg_addr  = 15'h0010;
        bus.cfg_data  = 4'h5;
        bus.req_valid = 4'b0011;
        set_addr(0, 15'h0010);
        set_addr(1, 15'h0020);
        #1;
        checks++;
        if (bus.req_ready !== 4'b0010 || bus.ram_addrb !== 15'h0020) begin
            errors++;
            $display("FAIL coll_grant got rdy=%b addrb=%h want 0010 0020",
                     bus.req_ready, bus.ram_addrb);
        end
        checks++;
        if (bus.ram_ena !== 1'b1 || bus.ram_wea !== 1'b1 || bus.ram_addra !== 15'h0010 ||
            bus.ram_dina !== 4'h5) begin
            errors++;
            $display("FAIL coll_write got ena=%b wea=%b addra=%h dina=%h want 1 1 0010 5",
                     bus.ram_ena, bus.ram_wea, bus.ram_addra, bus.ram_dina);
        end
        d1 = gold[15'h0020];
        gold[15'h0010] = 4'h5;
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1 || bus.rsp_data !== d1) begin
            errors++;
            $display("FAIL coll_rsp1 got v=%b id=%0d data=%h want 1 1 %h",
                     bus.rsp_valid, bus.rsp_id, bus.rsp_data, d1);
        end
        bus.cfg_valid = 1'b0;
        bus.req_valid = 4'b0001;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL coll_retry got %b want 0001", bus.req_ready);
        end
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 || bus.rsp_data !== 4'h5) begin
            errors++;
            $display("FAIL coll_rsp0 got v=%b id=%0d data=%h want 1 0 5",
                     bus.rsp_valid, bus.rsp_id, bus.rsp_data);
        end
        bus.req_valid = '0;
        m_last = 0;
    endtask

    task automatic test_update_lookup();
        int w;
        @(negedge clk);
        bus.cfg_valid = 1'b1;
        bus.cfg_addr  = 15'h7FFF;
        bus.cfg_data  = 4'h7;
        gold[15'h7FFF] = 4'h7;
        @(negedge clk);
        bus.cfg_valid = 1'b0;
        @(negedge clk);
        bus.req_valid = 4'b0001;
        set_addr(0, 15'h7FFF);
        #1;
        w = exp_winner(bus.req_valid, bus.req_addr, 1'b0, '0, m_last);
        checks++;
        if (bus.req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL upd_grant got %b want 0001", bus.req_ready);
        end
        if (w >= 0) m_last = w;
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 4'h7) begin
            errors++;
            $display("FAIL upd_rsp got v=%b data=%h want 1 7", bus.rsp_valid, bus.rsp_data);
        end
        bus.req_valid = '0;
    endtask

    task automatic test_random();
        int            w;
        int            prev_w;
        logic [DW-1:0] prev_data;
        prev_w    = -1;
        prev_data = '0;
        for (int c = 0; c <= 300; c++) begin
            @(negedge clk);
            checks++;
            if (prev_w >= 0) begin
                if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'(prev_w) ||
                    bus.rsp_data !== prev_data) begin
                    errors++;
                    $display("FAIL rand_rsp%0d got v=%b id=%0d data=%h want 1 %0d %h", c,
                             bus.rsp_valid, bus.rsp_id, bus.rsp_data, prev_w, prev_data);
                end
            end else if (bus.rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL rand_rsp%0d got v=%b want 0", c, bus.rsp_valid);
            end
            if (c == 300) begin
                zero_inputs();
            end else begin
                bus.req_valid = 4'($urandom);
                for (int i = 0; i < NR; i++) set_addr(i, pool[$urandom_range(0, 7)]);
                bus.cfg_valid = 1'($urandom);
                bus.cfg_addr  = pool[$urandom_range(0, 7)];
                bus.cfg_data  = 4'($urandom);
                #1;
                w = exp_winner(bus.req_valid, bus.req_addr, bus.cfg_valid, bus.cfg_addr, m_last);
                checks++;
                if (bus.req_ready !== ((w >= 0) ? 4'(1 << w) : 4'b0000) ||
                    bus.cfg_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL rand_grant%0d got rdy=%b cfg_rdy=%b want winner %0d", c,
                             bus.req_ready, bus.cfg_ready, w);
                end
                checks++;
                if (bus.ram_ena !== bus.cfg_valid ||
                    (bus.cfg_valid && bus.ram_addra !== bus.cfg_addr)) begin
                    errors++;
                    $display("FAIL rand_write%0d got ena=%b addra=%h want %b %h", c,
                             bus.ram_ena, bus.ram_addra, bus.cfg_valid, bus.cfg_addr);
                end
                prev_w = w;
                if (w >= 0) begin
                    m_last    = w;
                    prev_data = gold[bus.req_addr[w*AW +: AW]];
                end
                if (bus.cfg_valid) gold[bus.cfg_addr] = bus.cfg_data;
            end
        end
    endtask

    task automatic test_clear();
        int            w;
        int            busy;
        int            bad;
        int            prev_w;
        logic [AW-1:0] post [4];
        @(negedge clk);
        bus.clr_start = 1'b1;
        bus.cfg_valid = 1'b1;
        bus.cfg_addr  = 15'h1234;
        bus.cfg_data  = 4'h3;
        bus.req_valid = 4'b0001;
        set_addr(0, 15'h0100);
        #1;
        w = exp_winner(bus.req_valid, bus.req_addr, 1'b1, bus.cfg_addr, m_last);
        checks++;
        if (bus.cfg_ready !== 1'b1 || bus.req_ready !== 4'b0001 || w != 0) begin
            errors++;
            $display("FAIL clr_start_cycle got cfg_rdy=%b rdy=%b want 1 0001",
                     bus.cfg_ready, bus.req_ready);
        end
        m_last = 0;
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 || bus.rsp_data !== gold[15'h0100]) begin
            errors++;
            $display("FAIL clr_inflight_rsp got v=%b id=%0d data=%h want 1 0 %h",
                     bus.rsp_valid, bus.rsp_id, bus.rsp_data, gold[15'h0100]);
        end
        bus.clr_start = 1'b0;
        bus.req_valid = '1;
        bus.cfg_addr  = 15'h0050;
        busy = 0;
        bad  = 0;
        while (bus.clr_busy === 1'b1 && busy < 40000) begin
            #1;
            if (bus.req_ready !== 4'b0000 || bus.cfg_ready !== 1'b0 || bus.ram_enb !== 1'b0 ||
                bus.ram_ena !== 1'b1 || bus.ram_wea !== 1'b1 || bus.ram_dina !== 4'h0 ||
                bus.ram_addra !== AW'(busy) || (busy > 0 && bus.rsp_valid !== 1'b0)) begin
                if (bad == 0) begin
                    $display("FAIL clr_sweep at %0d got rdy=%b cfg_rdy=%b addra=%h dina=%h want 0 0 %h 0",
                             busy, bus.req_ready, bus.cfg_ready, bus.ram_addra, bus.ram_dina,
                             AW'(busy));
                end
                bad++;
            end
            busy++;
            bus.clr_start = (busy == 1000);  // ignored mid-sweep
            @(negedge clk);
        end
        zero_inputs();
        #1;
        checks++;
        if (busy != MEM || bad != 0) begin
            errors++;
            $display("FAIL clr_busy_len got %0d cycles (%0d bad) want %0d cycles", busy, bad, MEM);
        end
        checks++;
        if (bus.cfg_ready !== 1'b1 || bus.clr_busy !== 1'b0) begin
            errors++;
            $display("FAIL clr_done got cfg_rdy=%b busy=%b want 1 0", bus.cfg_ready, bus.clr_busy);
        end
        for (int a = 0; a < MEM; a++) gold[a] = '0;
        post   = '{15'h0000, 15'h4000, 15'h7FFF, 15'h1234};
        prev_w = 0;
        for (int k = 0; k <= 4; k++) begin
            if (k > 0) @(negedge clk);
            if (k > 0) begin
                checks++;
                if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'(prev_w) ||
                    bus.rsp_data !== gold[post[k-1]]) begin
                    errors++;
                    $display("FAIL clr_post%0d got v=%b id=%0d data=%h want 1 %0d 0", k - 1,
                             bus.rsp_valid, bus.rsp_id, bus.rsp_data, prev_w);
                end
            end
            if (k == 4) begin
                bus.req_valid = '0;
            end else begin
                bus.req_valid = 4'(1 << k);
                set_addr(k, post[k]);
                #1;
                w = exp_winner(bus.req_valid, bus.req_addr, 1'b0, '0, m_last);
                checks++;
                if (bus.req_ready !== 4'(1 << k) || w != k) begin
                    errors++;
                    $display("FAIL clr_post_grant%0d got %b want %b", k, bus.req_ready,
                             4'(1 << k));
                end
                m_last = w;
                prev_w = w;
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        logic found;
        @(negedge clk);
        bus.clr_start = 1'b1;
        @(negedge clk);
        bus.clr_start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            if (bus.clr_busy === 1'b1 && bus.ram_addra === 15'd100) found = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL midclr_reach got addra=%h busy=%b want sweep at 100",
                     bus.ram_addra, bus.clr_busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.rsp_valid, bus.clr_busy, bus.req_ready, bus.ram_ena, bus.ram_wea, bus.ram_enb,
             bus.ram_addra, bus.ram_dina, bus.ram_addrb, bus.rsp_id} !== '0) begin
            errors++;
            $display("FAIL midclr_reset got busy=%b ena=%b addra=%h rv=%b want all 0",
                     bus.clr_busy, bus.ram_ena, bus.ram_addra, bus.rsp_valid);
        end
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        m_last = NR - 1;
        #1;
        checks++;
        if (bus.cfg_ready !== 1'b1 || bus.clr_busy !== 1'b0) begin
            errors++;
            $display("FAIL midclr_idle got cfg_rdy=%b busy=%b want 1 0",
                     bus.cfg_ready, bus.clr_busy);
        end
        @(negedge clk);
        bus.cfg_valid = 1'b1;
        bus.cfg_addr  = 15'h2000;
        bus.cfg_data  = 4'hB;
        gold[15'h2000] = 4'hB;
        @(negedge clk);
        bus.cfg_valid = 1'b0;
        bus.req_valid = 4'b0010;
        set_addr(1, 15'h2000);
        @(negedge clk);
        bus.req_valid = '0;
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1 || bus.rsp_data !== 4'hB) begin
            errors++;
            $display("FAIL midclr_lookup got v=%b id=%0d data=%h want 1 1 b",
                     bus.rsp_valid, bus.rsp_id, bus.rsp_data);
        end
    endtask

    initial begin
        rst_n = 1'b1;
        zero_inputs();
        test_reset();
        preload();
        test_single_lookup();
        test_fairness();
        test_collision();
        test_update_lookup();
        test_random();
        test_clear();
        test_reset_mid_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
